// File: rtl/pipe_assign_chain.sv
// (a|b)^c through a DEPTH-stage valid/ready chain.
// mode_q picks one-stage-per-clock or whole-chain-in-one-clock scheduling.
module pipe_assign_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [WIDTH-1:0]           c,
  input  logic                       mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           z,
  output logic [WIDTH-1:0]           x_tap,
  output logic [WIDTH-1:0]           y_tap,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_nxt;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] ab;
  logic [WIDTH-1:0] abc;
  logic             mode_q;
  logic             free;
  logic             acc;

  assign ab  = a | b;
  assign abc = ab ^ c;

  // Walk from the output back; free means the stage below may load.
  always_comb begin
    adv  = '0;
    free = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i] = v[i] & free;
      free   = ~v[i] | adv[i];
    end
  end

  assign in_ready = mode_q ? (~v[DEPTH-1] | out_ready) : free;
  assign acc      = in_valid & in_ready;

  always_comb begin
    v_nxt = v;
    for (int i = 0; i < DEPTH; i++) begin
      if (adv[i]) v_nxt[i] = 1'b0;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (adv[i-1]) v_nxt[i] = 1'b1;
    end
    if (acc) begin
      if (mode_q) v_nxt[DEPTH-1] = 1'b1;
      else        v_nxt[0]       = 1'b1;
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OW'(v[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
      end
      v      <= '0;
      c_q    <= '0;
      mode_q <= 1'b0;
    end else begin
      if (!busy && !acc) mode_q <= mode;
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i-1]) d[i] <= (i == 1) ? (d[0] ^ c_q) : d[i-1];
      end
      if (acc) begin
        d[0] <= ab;
        if (!mode_q) c_q <= c;
      end
      // Collapsed: taps show the blocking intermediates.
      if (acc && mode_q) begin
        d[1]       <= abc;
        d[DEPTH-1] <= abc;
      end
      v <= v_nxt;
    end
  end

  assign busy      = |v;
  assign out_valid = v[DEPTH-1];
  assign z         = d[DEPTH-1];
  assign x_tap     = d[0];
  assign y_tap     = d[1];

endmodule
